// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multi-cycle mul/div stall sequencer.
package hazard_pkg;

  localparam int REG_ADDR_W         = 5;
  localparam int MD_LATENCY_DEFAULT = 4;
  localparam int MD_CNT_W           = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True when an instruction actually reads source rs and rs names rd.
  function automatic logic src_hit(input logic                  uses,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/md_stall_seq.sv
// Mul/div occupancy sequencer: freezes the pipeline for MD_LATENCY-1 cycles
// after an op enters EX, then pulses md_done for one cycle.
module md_stall_seq
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_md_start,
  output logic md_stall,
  output logic md_done
);

  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 2);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_md_start) begin
          md_stall = 1'b1;
          state_d  = MD_BUSY;
          cnt_d    = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
        end else begin
          // Result cycle: ex_md_start still shows the finishing op, so it is
          // deliberately not looked at here.
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: prioritises mul/div freeze, taken
// branch, load-use and unified-memory structural hazards; counts stall cycles.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic                  ex_branch_taken,
  input  logic                  ex_md_start,
  input  logic                  ex_mem_memaccess,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic                  md_done,
  output logic [15:0]           stall_cnt
);

  logic        md_stall;
  logic        seq_done;
  logic        load_use;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  md_stall_seq #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_stall_seq (
    .clk         (clk),
    .rst         (rst),
    .ex_md_start (ex_md_start),
    .md_stall    (md_stall),
    .md_done     (seq_done)
  );

  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    (src_hit(id_uses_rs1, id_rs1, id_ex_rd) ||
                     src_hit(id_uses_rs2, id_rs2, id_ex_rd));

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_done       = 1'b0;
    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (md_stall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else begin
      md_done = seq_done;
      if (ex_branch_taken) begin
        // PC loads the branch target even if MEM holds the shared memory.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        if (ex_mem_memaccess) begin
          pc_en = 1'b0;
          if (!load_use) begin
            if_id_flush = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MD_LATENCY=4): hand-computed
// control vectors plus a running expected stall count.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, id_ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_ex_memread;
  logic        ex_branch_taken, ex_md_start, ex_mem_memaccess;
  logic        pc_en, if_id_en, id_ex_en;
  logic        if_id_flush, id_ex_flush, ex_mem_bubble, md_done;
  logic [15:0] stall_cnt;

  int          errors = 0;
  int          checks = 0;
  int          exp_stall = 0;

  // Bit order: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, md_done}
  localparam logic [6:0] O_RST   = 7'b0001110;
  localparam logic [6:0] O_IDLE  = 7'b1110000;
  localparam logic [6:0] O_LU    = 7'b0010100;
  localparam logic [6:0] O_BR    = 7'b1111100;
  localparam logic [6:0] O_STRUC = 7'b0111000;
  localparam logic [6:0] O_MD    = 7'b0000010;
  localparam logic [6:0] O_DONE  = 7'b1110001;

  pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .id_ex_rd         (id_ex_rd),
    .id_ex_memread    (id_ex_memread),
    .ex_branch_taken  (ex_branch_taken),
    .ex_md_start      (ex_md_start),
    .ex_mem_memaccess (ex_mem_memaccess),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .id_ex_en         (id_ex_en),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_bubble    (ex_mem_bubble),
    .md_done          (md_done),
    .stall_cnt        (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_memread = 1'b0;
    ex_branch_taken = 1'b0; ex_md_start = 1'b0; ex_mem_memaccess = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    id_ex_memread = 1'b1; id_ex_rd = rd; id_rs1 = rd; id_uses_rs1 = 1'b1;
  endtask

  // Inputs are already applied; check outputs and count, then advance one cycle.
  task automatic step(input string tag, input logic [6:0] exp_o);
    logic [6:0] outs;
    #1;
    outs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, md_done};
    $display("step %-12s outs=%b stall_cnt=%0d", tag, outs, stall_cnt);
    check({tag, ".outs"}, 32'(outs), 32'(exp_o));
    check({tag, ".cnt"}, 32'(stall_cnt), 32'(exp_stall));
    if (rst) exp_stall = 0;
    else if (!exp_o[6] && exp_stall < 16'hFFFF) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step("reset0", O_RST);
    step("reset1", O_RST);
    rst = 1'b0;
    step("idle", O_IDLE);

    // Load-use via rs1, then zero-register and unused-source non-hazards
    set_load_use(5'd5);
    step("lu_rs1", O_LU);
    idle_inputs();
    step("after_lu", O_IDLE);
    id_ex_memread = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    step("lu_x0", O_IDLE);
    idle_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    step("lu_rs2", O_LU);
    idle_inputs();
    id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
    step("lu_unused", O_IDLE);

    // Branch beats load-use and structural hazards
    idle_inputs();
    set_load_use(5'd12); ex_branch_taken = 1'b1;
    step("br_lu", O_BR);
    ex_mem_memaccess = 1'b1;
    step("br_lu_mem", O_BR);

    // Structural hazard alone, then combined with load-use
    idle_inputs();
    ex_mem_memaccess = 1'b1;
    step("struct", O_STRUC);
    set_load_use(5'd20);
    step("struct_lu", O_LU);

    // Mul/div: first cycle also carries branch + load-use, which are ignored
    idle_inputs();
    ex_md_start = 1'b1; ex_branch_taken = 1'b1; set_load_use(5'd4);
    step("md0", O_MD);
    idle_inputs();
    ex_md_start = 1'b1;
    step("md1", O_MD);
    step("md2", O_MD);
    step("md_done", O_DONE);
    ex_md_start = 1'b0;
    step("md_after", O_IDLE);

    // Reset in the second MD_BUSY cycle abandons the op
    ex_md_start = 1'b1;
    step("mdr0", O_MD);
    ex_md_start = 1'b0;
    step("mdr1", O_MD);
    rst = 1'b1;
    step("mdr_rst", O_RST);
    rst = 1'b0;
    step("mdr_post0", O_IDLE);
    step("mdr_post1", O_IDLE);
    step("mdr_post2", O_IDLE);

    // Saturation: 65540 consecutive stall cycles
    ex_mem_memaccess = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("sat", 32'(stall_cnt), 32'h0000FFFF);
    exp_stall = 16'hFFFF;
    step("sat_hold0", O_STRUC);
    step("sat_hold1", O_STRUC);
    idle_inputs();
    step("sat_idle", O_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, meaning total EX cycles of a multi-cycle mul/div op; legal range 2..16.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-006 SHALL have ports id_ex_rd  in  5 and id_ex_memread  in  1  describing the load in EX.
REQ-007 SHALL have port ex_branch_taken  in  1  branch or jump in EX resolved taken.
REQ-008 SHALL have port ex_md_start  in  1  a mul/div op occupies EX.
REQ-009 SHALL have port ex_mem_memaccess  in  1  the instruction in MEM uses the shared unified memory.
REQ-010 SHALL have ports pc_en, if_id_en, id_ex_en  out  1 each  pipeline register write enables.
REQ-011 SHALL have ports if_id_flush, id_ex_flush, ex_mem_bubble  out  1 each  insert NOP into that register.
REQ-012 SHALL have port md_done  out  1  one-cycle pulse: mul/div result valid this cycle.
REQ-013 SHALL have port stall_cnt  out  16  saturating count of cycles with pc_en=0.

Function
REQ-014 SHALL implement an FSM with states RUN and MD_BUSY, plus a 4-bit down-counter.
REQ-015 A hazard is load_use = id_ex_memread & id_ex_rd!=0 & ((id_uses_rs1 & id_rs1==id_ex_rd) | (id_uses_rs2 & id_rs2==id_ex_rd)).
REQ-016 Default (no event): pc_en=if_id_en=id_ex_en=1, all flush/bubble outputs=0, md_done=0.
REQ-017 MD stall, highest priority: in RUN with ex_md_start=1, or in MD_BUSY with counter!=0, pc_en=if_id_en=id_ex_en=0 and ex_mem_bubble=1. All other events are ignored.
REQ-018 On RUN with ex_md_start=1, the FSM SHALL enter MD_BUSY with counter=MD_LATENCY-2.
REQ-019 In MD_BUSY with counter!=0, the counter SHALL decrement.
REQ-020 In MD_BUSY with counter==0, the block SHALL assert md_done=1 and apply no MD stall; the FSM returns to RUN. ex_md_start is not re-sampled in this cycle. The net effect is exactly MD_LATENCY-1 frozen cycles.
REQ-021 Branch, second priority: when ex_branch_taken=1, the block SHALL drive pc_en=1, if_id_flush=1, id_ex_flush=1. Load-use is suppressed. This applies regardless of ex_mem_memaccess, since the PC still loads the target.
REQ-022 Load-use, third priority: the block SHALL drive pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle per occurrence.
REQ-023 Structural hazard: when ex_mem_memaccess=1 and neither branch nor MD stall is active, the block SHALL force pc_en=0. If load-use is also active, IF/ID holds (REQ-022). Otherwise if_id_flush=1 and if_id_en=1.
REQ-024 Outputs SHALL be combinational from inputs and registered state, with zero-cycle latency.
REQ-025 stall_cnt SHALL increment in every cycle where pc_en=0 and rst=0. It saturates at 16'hFFFF.
REQ-026 If rst asserts in MD_BUSY, the op SHALL be abandoned and md_done is never pulsed for it.

Reset
REQ-027 While rst=1, the block SHALL drive pc_en=if_id_en=id_ex_en=0, if_id_flush=id_ex_flush=ex_mem_bubble=1, md_done=0.
REQ-028 On the first edge with rst=1, state SHALL be RUN, counter=0, and stall_cnt=0.
REQ-029 Normal operation SHALL begin on the first edge after rst deasserts.

Structure
REQ-030 The shared package hazard_pkg SHALL hold the FSM state enum (RUN, MD_BUSY), REG_ADDR_W=5, and MD_LATENCY_DEFAULT=4.
REQ-031 The FSM and down-counter SHALL be one sub-module, md_stall_seq, with outputs md_stall and md_done.
REQ-032 Priority muxing and stall_cnt SHALL live in the top module.

Verification
REQ-033 Load-use: id_ex_memread=1, id_ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1. id_ex_rd=0 with id_rs1=0 -> no stall.
REQ-034 Branch with load-use: ex_branch_taken=1 and load-use both true -> pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1.
REQ-035 MD op, MD_LATENCY=4: ex_md_start held high -> 3 cycles with pc_en=0 and ex_mem_bubble=1, then md_done=1 for exactly 1 cycle with pc_en=1. stall_cnt advances by 3.
REQ-036 Structural hazard: ex_mem_memaccess=1 alone -> pc_en=0, if_id_flush=1. Adding load-use -> if_id_en=0, id_ex_flush=1, if_id_flush=0.
REQ-037 Reset mid-op: rst=1 in the 2nd MD_BUSY cycle -> state RUN and stall_cnt=0 next cycle; no md_done pulse.
REQ-038 Saturation: force 65540 consecutive pc_en=0 cycles -> stall_cnt=16'hFFFF and holds.
